// File: rtl/two_bit_comparator.sv
// -----------------------------------------------------------------------------
// two_bit_comparator
//
// Registered magnitude comparator for two 2-bit unsigned operands
// A = {A1,A0} and B = {B1,B0}. Every accepted sample (in_valid high on a
// rising clk edge) produces one-hot greater / less / equal flags one cycle
// later. The flags hold until the next accepted sample. out_valid marks the
// single cycle that follows each accepted sample.
//
// Optional statistics block, enabled by defining TWO_BIT_COMPARATOR_STATS_EN:
// three saturating 8-bit counters, one per result category, with a
// synchronous clear.
//
// Ports:
//   clk        in   1  rising-edge clock for all state
//   rst_n      in   1  asynchronous active-low reset
//   A1, A0     in   1  operand A (MSB, LSB)
//   B1, B0     in   1  operand B (MSB, LSB)
//   in_valid   in   1  sample operands on this edge
//   A_gt_B     out  1  registered flag, A > B
//   A_lt_B     out  1  registered flag, A < B
//   A_eq_B     out  1  registered flag, A == B
//   out_valid  out  1  high for one cycle after each accepted sample
//   stats_clr  in   1  synchronous clear of all counters   (stats build only)
//   gt_count   out  8  saturating count of A > B results   (stats build only)
//   lt_count   out  8  saturating count of A < B results   (stats build only)
//   eq_count   out  8  saturating count of A == B results  (stats build only)
// -----------------------------------------------------------------------------
module two_bit_comparator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A1,
    input  logic       A0,
    input  logic       B1,
    input  logic       B0,
    input  logic       in_valid,
    output logic       A_gt_B,
    output logic       A_lt_B,
    output logic       A_eq_B,
    output logic       out_valid
`ifdef TWO_BIT_COMPARATOR_STATS_EN
    ,
    input  logic       stats_clr,
    output logic [7:0] gt_count,
    output logic [7:0] lt_count,
    output logic [7:0] eq_count
`endif
);

    // Combinational compare of the current operands. The MSBs decide the
    // result unless they match, in which case the LSBs decide.
    logic msb_same;
    logic gt;
    logic lt;
    logic eq;

    assign msb_same = ~(A1 ^ B1);
    assign gt       = (A1 & ~B1) | (msb_same & A0 & ~B0);
    assign lt       = (~A1 & B1) | (msb_same & ~A0 & B0);
    assign eq       = msb_same & ~(A0 ^ B0);

    // Result registers. The flags only load on an accepted sample, so the
    // all-zero state is reachable only between reset and the first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A_gt_B    <= 1'b0;
            A_lt_B    <= 1'b0;
            A_eq_B    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            out_valid <= in_valid;
            if (in_valid) begin
                A_gt_B <= gt;
                A_lt_B <= lt;
                A_eq_B <= eq;
            end
        end
    end

`ifdef TWO_BIT_COMPARATOR_STATS_EN
    // Saturating increment: a full counter stays at 255 rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    logic [7:0] gt_count_next;
    logic [7:0] lt_count_next;
    logic [7:0] eq_count_next;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a value unassigned and no latch is inferred.
        gt_count_next = gt_count;
        lt_count_next = lt_count;
        eq_count_next = eq_count;
        if (stats_clr) begin
            // Clear wins over an increment arriving in the same cycle.
            gt_count_next = 8'd0;
            lt_count_next = 8'd0;
            eq_count_next = 8'd0;
        end else if (in_valid) begin
            if (gt) gt_count_next = sat_inc(gt_count);
            if (lt) lt_count_next = sat_inc(lt_count);
            if (eq) eq_count_next = sat_inc(eq_count);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_count <= 8'd0;
            lt_count <= 8'd0;
            eq_count <= 8'd0;
        end else begin
            gt_count <= gt_count_next;
            lt_count <= lt_count_next;
            eq_count <= eq_count_next;
        end
    end
`endif

endmodule

// File: tb/tb_two_bit_comparator.sv
// -----------------------------------------------------------------------------
// tb_two_bit_comparator
//
// Self-checking bench for two_bit_comparator. A behavioural model compares
// the operands as integers and tracks the expected flags, out_valid and, in
// the stats build, the saturating counters. A single process compares the DUT
// against the model on every falling edge; literal checks pin the model at
// the reset, spot-check, hold and saturation points.
// -----------------------------------------------------------------------------
module tb_two_bit_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic A1 = 1'b0, A0 = 1'b0, B1 = 1'b0, B0 = 1'b0;
    logic in_valid = 1'b0;
    logic A_gt_B, A_lt_B, A_eq_B, out_valid;
`ifdef TWO_BIT_COMPARATOR_STATS_EN
    logic       stats_clr = 1'b0;
    logic [7:0] gt_count, lt_count, eq_count;
`endif

    two_bit_comparator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A1        (A1),
        .A0        (A0),
        .B1        (B1),
        .B0        (B0),
        .in_valid  (in_valid),
        .A_gt_B    (A_gt_B),
        .A_lt_B    (A_lt_B),
        .A_eq_B    (A_eq_B),
        .out_valid (out_valid)
`ifdef TWO_BIT_COMPARATOR_STATS_EN
        ,
        .stats_clr (stats_clr),
        .gt_count  (gt_count),
        .lt_count  (lt_count),
        .eq_count  (eq_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state. Flags are encoded as {gt,lt,eq}: 4 = A>B, 2 = A<B, 1 = A==B.
    int exp_flags = 0;
    int exp_valid = 0;
    int exp_gt_cnt = 0, exp_lt_cnt = 0, exp_eq_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int relation(input int a, input int b);
        if (a > b) return 4;
        if (a < b) return 2;
        return 1;
    endfunction

    function automatic int bump(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    task automatic model_reset();
        exp_flags  = 0;
        exp_valid  = 0;
        exp_gt_cnt = 0;
        exp_lt_cnt = 0;
        exp_eq_cnt = 0;
    endtask

    // Drive one cycle of stimulus, let the edge happen, then advance the model.
    task automatic step(input int a, input int b, input bit v, input bit clr);
        A1       = a[1];
        A0       = a[0];
        B1       = b[1];
        B0       = b[0];
        in_valid = v;
`ifdef TWO_BIT_COMPARATOR_STATS_EN
        stats_clr = clr;
`endif
        @(posedge clk);
        exp_valid = int'(v);
        if (v) exp_flags = relation(a, b);
        if (clr) begin
            exp_gt_cnt = 0;
            exp_lt_cnt = 0;
            exp_eq_cnt = 0;
        end else if (v) begin
            case (relation(a, b))
                4:       exp_gt_cnt = bump(exp_gt_cnt);
                2:       exp_lt_cnt = bump(exp_lt_cnt);
                default: exp_eq_cnt = bump(exp_eq_cnt);
            endcase
        end
        #1;
    endtask

    function automatic int flags();
        return int'({A_gt_B, A_lt_B, A_eq_B});
    endfunction

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("flags", flags(), exp_flags);
            check("out_valid", int'(out_valid), exp_valid);
            if (exp_flags != 0)
                check("one_hot", $countones({A_gt_B, A_lt_B, A_eq_B}), 1);
`ifdef TWO_BIT_COMPARATOR_STATS_EN
            check("gt_count", int'(gt_count), exp_gt_cnt);
            check("lt_count", int'(lt_count), exp_lt_cnt);
            check("eq_count", int'(eq_count), exp_eq_cnt);
`endif
        end
    end

    // Assert reset between edges, check outputs clear immediately, then
    // release it away from the clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_flags"}, flags(), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
`ifdef TWO_BIT_COMPARATOR_STATS_EN
        check({tag, "_counts"}, int'(gt_count) + int'(lt_count) + int'(eq_count), 0);
`endif
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    int spot_a[6]   = '{0, 1, 1, 2, 3, 3};
    int spot_b[6]   = '{1, 0, 1, 1, 2, 3};
    int spot_exp[6] = '{2, 4, 1, 4, 4, 1};

    initial begin
        A1 = 1'b1; A0 = 1'b0; B1 = 1'b1; B0 = 1'b1;   // arbitrary operands in reset
        #2;
        do_reset("reset");
        chk_en = 1'b1;

        // First sample after reset: 00 vs 00 -> equal.
        step(0, 0, 1'b1, 1'b0);
        check("first_eq", flags(), 1);
        check("first_valid", int'(out_valid), 1);

        // Spot checks against hand-computed results.
        for (int i = 0; i < 6; i++) begin
            step(spot_a[i], spot_b[i], 1'b1, 1'b0);
            check($sformatf("spot_%0d_%0d", spot_a[i], spot_b[i]), flags(), spot_exp[i]);
        end

        // Exhaustive back-to-back sweep.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                step(a, b, 1'b1, 1'b0);

        // Hold: 11 vs 10 accepted, then new operands with in_valid low.
        step(3, 2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 3, 1'b0, 1'b0);
            check("hold_gt", flags(), 4);
            check("hold_valid", int'(out_valid), 0);
        end

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

        // Async reset mid-stream while A_gt_B is high.
        step(2, 0, 1'b1, 1'b0);
        check("pre_reset_gt", flags(), 4);
        #2;
        do_reset("mid_reset");
        step(1, 0, 1'b1, 1'b0);
        check("post_reset_gt", flags(), 4);

`ifdef TWO_BIT_COMPARATOR_STATS_EN
        // Saturation: 300 samples of 10 vs 01 from a clean reset.
        do_reset("stats_reset");
        for (int i = 0; i < 300; i++)
            step(2, 1, 1'b1, 1'b0);
        check("sat_gt", int'(gt_count), 255);
        check("sat_lt", int'(lt_count), 0);
        check("sat_eq", int'(eq_count), 0);

        // Clear beats a simultaneous increment.
        step(3, 3, 1'b1, 1'b1);
        check("clr_gt", int'(gt_count), 0);
        check("clr_lt", int'(lt_count), 0);
        check("clr_eq", int'(eq_count), 0);
        check("clr_flags", flags(), 1);
        step(3, 3, 1'b1, 1'b0);
        check("after_clr_eq", int'(eq_count), 1);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
